// File: rtl/alu_mp_sequencer_pkg.sv
// alu_seq_pkg: shared types and constants for the multi-precision add/subtract
// sequencer and its 64-bit adder.
//   WORD_W        width of one operand/result word
//   OP_ADD/OP_SUB encoding of the sub_i command bit
//   seq_state_e   sequencer control states
//   clamp_words   limits a requested word count (minus one) to the supported maximum
package alu_seq_pkg;

    localparam int WORD_W = 64;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } seq_state_e;

    // Word count arrives as "count minus one"; anything past the last
    // supported word index is pulled back to it.
    function automatic int unsigned clamp_words(input int unsigned words_m1,
                                                input int unsigned words_max);
        return (words_m1 > words_max - 1) ? words_max - 1 : words_m1;
    endfunction

endpackage

// File: rtl/alu_mp_sequencer_if.sv
// alu_mp_sequencer_if: command, operand stream, result stream and status
// signals between the execute-stage control (master) and the sequencer (slave).
//   command : start_i, sub_i, cin_i, words_i, abort_i
//   operand : op_valid_i, op_ready_o, opA_i, opB_i
//   result  : res_valid_o, res_ready_i, res_o, res_last_o
//   status  : busy_o, done_o, cflag_o, vflag_o, zflag_o, nflag_o
interface alu_mp_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int CNT_W = 2
);
    logic              start_i;
    logic              sub_i;
    logic              cin_i;
    logic [CNT_W-1:0]  words_i;
    logic              abort_i;

    logic              op_valid_i;
    logic              op_ready_o;
    logic [WORD_W-1:0] opA_i;
    logic [WORD_W-1:0] opB_i;

    logic              res_valid_o;
    logic              res_ready_i;
    logic [WORD_W-1:0] res_o;
    logic              res_last_o;

    logic              busy_o;
    logic              done_o;
    logic              cflag_o;
    logic              vflag_o;
    logic              zflag_o;
    logic              nflag_o;

    modport master (
        output start_i, sub_i, cin_i, words_i, abort_i,
        output op_valid_i, opA_i, opB_i, res_ready_i,
        input  op_ready_o, res_valid_o, res_o, res_last_o,
        input  busy_o, done_o, cflag_o, vflag_o, zflag_o, nflag_o
    );

    modport slave (
        input  start_i, sub_i, cin_i, words_i, abort_i,
        input  op_valid_i, opA_i, opB_i, res_ready_i,
        output op_ready_o, res_valid_o, res_o, res_last_o,
        output busy_o, done_o, cflag_o, vflag_o, zflag_o, nflag_o
    );

endinterface

// File: rtl/alu_mp_sequencer_alu.sv
// alu: combinational 64-bit adder with carry in and C/V/Z outputs.
//   a_i, b_i  operands (subtraction is done by the caller inverting b_i)
//   cflag_i   carry in
//   out_o     sum
//   cflag_o   carry out, vflag_o signed overflow, zflag_o sum is zero
module alu
    import alu_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic              cflag_i,
    output logic [WORD_W-1:0] out_o,
    output logic              cflag_o,
    output logic              vflag_o,
    output logic              zflag_o
);

    always_comb begin
        {cflag_o, out_o} = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, cflag_i};
        // Overflow: both operands share a sign that the sum does not.
        vflag_o = (a_i[WORD_W-1] == b_i[WORD_W-1]) && (out_o[WORD_W-1] != a_i[WORD_W-1]);
        zflag_o = (out_o == '0);
    end

endmodule

// File: rtl/alu_mp_sequencer.sv
// alu_mp_sequencer: streams operand word pairs (least significant first)
// through the shared 64-bit alu with the carry chained across words, and
// returns result words plus whole-number C/V/Z/N flags.
//   clk_i, reset_i  clock, asynchronous active-high reset
//   bus (slave)     command, operand/result handshakes, busy/done and flags
module alu_mp_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WORDS_MAX = 4,
    parameter int CNT_W     = 2
)(
    input  logic               clk_i,
    input  logic               reset_i,
    alu_mp_sequencer_if.slave  bus
);

    seq_state_e        state_q, state_d;
    logic              op_ready;
    logic              busy;
    logic              accept;
    logic              res_hs;
    logic              last_word;

    logic              sub_q;
    logic [CNT_W-1:0]  words_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              carry_q;
    logic              zacc_q;
    logic [WORD_W-1:0] res_q;
    logic              res_valid_q;
    logic              res_last_q;
    logic              done_q;
    logic              c_q, v_q, z_q, n_q;

    logic [WORD_W-1:0] alu_b;
    logic [WORD_W-1:0] alu_out;
    logic              alu_c, alu_v, alu_z;

    // Subtraction is A + ~B + carry, with carry = 1 meaning "no borrow".
    assign alu_b = (sub_q == OP_SUB) ? ~bus.opB_i : bus.opB_i;

    alu u_alu (
        .a_i     (bus.opA_i),
        .b_i     (alu_b),
        .cflag_i (carry_q),
        .out_o   (alu_out),
        .cflag_o (alu_c),
        .vflag_o (alu_v),
        .zflag_o (alu_z)
    );

    assign accept    = bus.op_valid_i && op_ready;
    assign res_hs    = res_valid_q && bus.res_ready_i;
    assign last_word = (cnt_q == words_q);

    // NOTE: state register and datapath use non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        op_ready = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE:  if (bus.start_i) state_d = RUN;
            RUN: begin
                // Abort wins over any handshake in the same cycle.
                op_ready = (!res_valid_q || bus.res_ready_i) && !bus.abort_i;
                if (op_ready && bus.op_valid_i && last_word) state_d = FLUSH;
            end
            FLUSH: if (res_hs && res_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.abort_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sub_q       <= OP_ADD;
            words_q     <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            done_q      <= 1'b0;
            {c_q, v_q, z_q, n_q} <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort_i) begin
                res_valid_q <= 1'b0;
                res_last_q  <= 1'b0;
            end else if (state_q == IDLE) begin
                if (bus.start_i) begin
                    sub_q   <= bus.sub_i;
                    words_q <= CNT_W'(clamp_words(32'(bus.words_i), WORDS_MAX));
                    carry_q <= bus.cin_i ^ bus.sub_i;
                    cnt_q   <= '0;
                    zacc_q  <= 1'b1;
                    {c_q, v_q, z_q, n_q} <= '0;
                end
            end else begin
                if (res_hs) begin
                    res_valid_q <= 1'b0;
                    res_last_q  <= 1'b0;
                    if (res_last_q) done_q <= 1'b1;
                end
                // A new accept in the same edge overrides the clear above.
                if (accept) begin
                    res_q       <= alu_out;
                    res_valid_q <= 1'b1;
                    res_last_q  <= last_word;
                    carry_q     <= alu_c;
                    zacc_q      <= zacc_q & alu_z;
                    cnt_q       <= cnt_q + CNT_W'(1);
                    if (last_word) begin
                        c_q <= alu_c;
                        v_q <= alu_v;
                        z_q <= zacc_q & alu_z;
                        n_q <= alu_out[WORD_W-1];
                    end
                end
            end
        end
    end

    assign bus.op_ready_o  = op_ready;
    assign bus.res_valid_o = res_valid_q;
    assign bus.res_o       = res_q;
    assign bus.res_last_o  = res_last_q;
    assign bus.busy_o      = busy;
    assign bus.done_o      = done_q;
    assign bus.cflag_o     = c_q;
    assign bus.vflag_o     = v_q;
    assign bus.zflag_o     = z_q;
    assign bus.nflag_o     = n_q;

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// tb_alu_mp_sequencer: directed and randomized checks of alu_mp_sequencer
// against a whole-number arithmetic model.
module tb_alu_mp_sequencer;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_mp_sequencer_if #(.CNT_W(2)) bus();

    alu_mp_sequencer #(.WORDS_MAX(4), .CNT_W(2)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Whole-number reference: n*64-bit add or subtract of A and B.
    task automatic model(input logic [255:0] a, input logic [255:0] b, input int n,
                         input logic sub, input logic cin,
                         output logic [255:0] r, output logic c, output logic v,
                         output logic z, output logic nf);
        logic [256:0] m, am, bm, t;
        int top;
        m   = (257'(1) << (64 * n)) - 257'(1);
        am  = {1'b0, a} & m;
        bm  = {1'b0, b} & m;
        top = 64 * n - 1;
        if (!sub) begin
            t = am + bm + 257'(cin);
            c = t[64 * n];
        end else begin
            t = am - bm - 257'(cin);
            c = (am >= bm + 257'(cin));
        end
        r  = t[255:0] & m[255:0];
        nf = r[top];
        z  = (r == '0);
        if (!sub) v = (a[top] == b[top]) && (r[top] != a[top]);
        else      v = (a[top] != b[top]) && (r[top] != a[top]);
    endtask

    task automatic send_start(input int n, input logic sub, input logic cin);
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.sub_i   = sub;
        bus.cin_i   = cin;
        bus.words_i = 2'(n - 1);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.sub_i   = 1'($urandom);
        bus.cin_i   = 1'($urandom);
        bus.words_i = 2'($urandom);
    endtask

    task automatic drive_ops(input logic [255:0] a, input logic [255:0] b, input int n, input bit stall);
        for (int w = 0; w < n; w++) begin
            bit acc = 1'b0;
            int cyc = 0;
            bus.opA_i = a[w*64 +: 64];
            bus.opB_i = b[w*64 +: 64];
            while (!acc && cyc < 300) begin
                bus.op_valid_i = stall || ($urandom_range(3) != 0);
                @(negedge clk);
                acc = bus.op_valid_i && bus.op_ready_o;
                @(posedge clk); #1;
                cyc++;
            end
            if (!acc) begin
                check("drive_timeout", 64'd0, 64'd1);
                bus.op_valid_i = 1'b0;
                return;
            end
        end
        bus.op_valid_i = 1'b0;
    endtask

    task automatic collect(input string tag, input logic [255:0] r, input int n,
                           input bit stall, output bit ok);
        ok = 1'b1;
        if (stall) begin
            int cyc = 0;
            bus.res_ready_i = 1'b0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!bus.res_valid_o && cyc < 300);
            for (int k = 0; k < 3; k++) begin
                if (k > 0) @(negedge clk);
                check({tag, ":stall_valid"}, 64'(bus.res_valid_o), 64'd1);
                check({tag, ":stall_op_ready"}, 64'(bus.op_ready_o), 64'd0);
                check({tag, ":stall_hold"}, bus.res_o, r[63:0]);
                @(posedge clk); #1;
            end
            bus.res_ready_i = 1'b1;
        end
        for (int w = 0; w < n; w++) begin
            bit got = 1'b0;
            int cyc = 0;
            while (!got && cyc < 300) begin
                @(negedge clk);
                if (bus.res_valid_o && bus.res_ready_i) begin
                    got = 1'b1;
                    check($sformatf("%s:res%0d", tag, w), bus.res_o, r[w*64 +: 64]);
                    check($sformatf("%s:last%0d", tag, w), 64'(bus.res_last_o), 64'(w == n - 1));
                end
                @(posedge clk); #1;
                cyc++;
                if (!stall) bus.res_ready_i = ($urandom_range(3) != 0);
            end
            if (!got) begin
                check({tag, ":result_timeout"}, 64'd0, 64'd1);
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [255:0] a, input logic [255:0] b,
                          input int n, input logic sub, input logic cin, input bit stall);
        logic [255:0] r;
        logic ec, ev, ez, en;
        bit ok;
        model(a, b, n, sub, cin, r, ec, ev, ez, en);
        send_start(n, sub, cin);
        check({tag, ":busy"}, 64'(bus.busy_o), 64'd1);
        bus.res_ready_i = 1'b1;
        fork
            drive_ops(a, b, n, stall);
            collect(tag, r, n, stall, ok);
        join
        bus.op_valid_i  = 1'b0;
        bus.res_ready_i = 1'b0;
        if (ok) begin
            @(negedge clk);
            check({tag, ":done"}, 64'(bus.done_o), 64'd1);
            check({tag, ":busy_off"}, 64'(bus.busy_o), 64'd0);
            @(negedge clk);
            check({tag, ":done_pulse"}, 64'(bus.done_o), 64'd0);
        end
        check({tag, ":C"}, 64'(bus.cflag_o), 64'(ec));
        check({tag, ":V"}, 64'(bus.vflag_o), 64'(ev));
        check({tag, ":Z"}, 64'(bus.zflag_o), 64'(ez));
        check({tag, ":N"}, 64'(bus.nflag_o), 64'(en));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ":op_ready"},  64'(bus.op_ready_o),  64'd0);
        check({tag, ":res_valid"}, 64'(bus.res_valid_o), 64'd0);
        check({tag, ":res_last"},  64'(bus.res_last_o),  64'd0);
        check({tag, ":busy"},      64'(bus.busy_o),      64'd0);
        check({tag, ":done"},      64'(bus.done_o),      64'd0);
        check({tag, ":res"},       bus.res_o,            64'd0);
        check({tag, ":flags"}, 64'({bus.cflag_o, bus.vflag_o, bus.zflag_o, bus.nflag_o}), 64'd0);
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] x;
        for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
        case ($urandom_range(5))
            0: x = '1;
            1: x = '0;
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [255:0] a, b;
        int n;
        bit acc;

        bus.start_i = 0; bus.sub_i = 0; bus.cin_i = 0; bus.words_i = '0; bus.abort_i = 0;
        bus.op_valid_i = 0; bus.opA_i = '0; bus.opB_i = '0; bus.res_ready_i = 0;
        rst = 1'b1;
        #1;
        check_reset_values("reset");
        #11 rst = 1'b0;

        // Directed cases.
        run_op("add2", 256'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 256'd1, 2, 1'b0, 1'b0, 1'b0);
        run_op("sub5m5", 256'd5, 256'd5, 1, 1'b1, 1'b0, 1'b0);
        run_op("sub0m1", 256'd0, 256'd1, 1, 1'b1, 1'b0, 1'b0);
        run_op("ovf", 256'h4000_0000_0000_0000, 256'h4000_0000_0000_0000, 1, 1'b0, 1'b0, 1'b0);
        run_op("stall4", rand256(), rand256(), 4, 1'b0, 1'($urandom), 1'b1);

        // Abort during the third word of four.
        send_start(4, 1'b0, 1'b0);
        bus.res_ready_i = 1'b1;
        for (int w = 0; w < 2; w++) begin
            bus.op_valid_i = 1'b1;
            bus.opA_i = 64'(w + 10);
            bus.opB_i = 64'(w + 20);
            @(negedge clk);
            acc = bus.op_ready_o;
            @(posedge clk); #1;
            check($sformatf("abort:accept%0d", w), 64'(acc), 64'd1);
        end
        bus.abort_i = 1'b1;
        @(posedge clk); #1;
        bus.abort_i    = 1'b0;
        bus.op_valid_i = 1'b0;
        check("abort:busy", 64'(bus.busy_o), 64'd0);
        check("abort:res_valid", 64'(bus.res_valid_o), 64'd0);
        check("abort:op_ready", 64'(bus.op_ready_o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort:no_done", 64'(bus.done_o), 64'd0);
        end
        run_op("post_abort", rand256(), rand256(), 3, 1'b1, 1'b0, 1'b0);

        // Reset while in RUN with a result pending.
        send_start(2, 1'b1, 1'b0);
        bus.res_ready_i = 1'b0;
        bus.op_valid_i  = 1'b1;
        bus.opA_i = 64'd0;
        bus.opB_i = 64'd1;
        @(posedge clk); #1;
        bus.op_valid_i = 1'b0;
        check("rstrun:pre_valid", 64'(bus.res_valid_o), 64'd1);
        check("rstrun:pre_res", bus.res_o, 64'hFFFF_FFFF_FFFF_FFFF);
        #2 rst = 1'b1;
        #1 check_reset_values("rstrun");
        @(negedge clk) rst = 1'b0;

        // Reset in FLUSH, after the flags have been set.
        send_start(1, 1'b1, 1'b0);
        bus.res_ready_i = 1'b0;
        bus.op_valid_i  = 1'b1;
        bus.opA_i = 64'd0;
        bus.opB_i = 64'd1;
        @(posedge clk); #1;
        bus.op_valid_i = 1'b0;
        check("rstflush:pre_n", 64'(bus.nflag_o), 64'd1);
        check("rstflush:pre_last", 64'(bus.res_last_o), 64'd1);
        #2 rst = 1'b1;
        #1 check_reset_values("rstflush");
        @(negedge clk) rst = 1'b0;

        // Randomized operations with random valid gaps and backpressure.
        for (int i = 0; i < 25; i++) begin
            a = rand256();
            b = rand256();
            n = $urandom_range(4, 1);
            run_op($sformatf("rnd%0d", i), a, b, n, 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
